// File: rtl/uart_frame_parser.sv
// Command-frame delineator behind uart_rx: HEADER, cmd, len, payload, XOR checksum.
// Payload goes out through a fall-through FIFO. Optional macro UFP_TIMEOUT_EN adds an inter-byte timeout.
module uart_frame_parser #(
    parameter int          FIFO_DEPTH     = 16,
    parameter int          MAX_LEN        = 64,
    parameter logic [7:0]  HEADER         = 8'hAA,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] frame_cmd,
    output logic       frame_done,
    output logic       frame_ok,
    output logic [2:0] err_code,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, CMD, LEN, PAYLOAD, CHK} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);

    state_t      state;
    logic [7:0]  chk;
    logic [7:0]  cnt;
    logic        ovf;
    logic [8:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0] count;
    logic        full;
    logic        pop;
    logic        push_req;
    logic        push_ok;
    logic        timeout_hit;

    // Output handshake: a byte transfers on every clk edge where out_valid && out_ready.
    // out_valid never depends on out_ready, and the head stays stable until it transfers.
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr][7:0] : 8'h00;
    assign out_last  = out_valid ? mem[rd_ptr][8]   : 1'b0;
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign pop       = out_valid & out_ready;
    assign push_req  = rx_done && (state == PAYLOAD);
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign push_ok   = push_req && (!full || pop);
    assign busy      = (state != IDLE);

`ifdef UFP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (rx_done || !busy) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign timeout_hit = busy && !rx_done && (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {(cnt == 8'd1), rx_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            chk        <= 8'h00;
            cnt        <= 8'h00;
            ovf        <= 1'b0;
            frame_cmd  <= 8'h00;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err_code   <= 3'd0;
        end else begin
            frame_done <= 1'b0;
            if (timeout_hit) begin
                frame_done <= 1'b1;
                frame_ok   <= 1'b0;
                err_code   <= 3'd4;
                ovf        <= 1'b0;
                state      <= IDLE;
            end else if (rx_done) begin
                case (state)
                    IDLE: begin
                        if (rx_data == HEADER) begin
                            state <= CMD;
                        end
                    end
                    CMD: begin
                        frame_cmd <= rx_data;
                        chk       <= rx_data;
                        state     <= LEN;
                    end
                    LEN: begin
                        if (rx_data > 8'(MAX_LEN)) begin
                            frame_done <= 1'b1;
                            frame_ok   <= 1'b0;
                            err_code   <= 3'd2;
                            ovf        <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            chk   <= chk ^ rx_data;
                            cnt   <= rx_data;
                            state <= (rx_data != 8'h00) ? PAYLOAD : CHK;
                        end
                    end
                    PAYLOAD: begin
                        chk <= chk ^ rx_data;
                        cnt <= cnt - 8'd1;
                        if (push_req && !push_ok) begin
                            ovf <= 1'b1;
                        end
                        if (cnt == 8'd1) begin
                            state <= CHK;
                        end
                    end
                    CHK: begin
                        // Overflow outranks a checksum mismatch.
                        frame_done <= 1'b1;
                        if (ovf) begin
                            frame_ok <= 1'b0;
                            err_code <= 3'd3;
                        end else if (rx_data != chk) begin
                            frame_ok <= 1'b0;
                            err_code <= 3'd1;
                        end else begin
                            frame_ok <= 1'b1;
                            err_code <= 3'd0;
                        end
                        ovf   <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed frame table, hand-written corner sequences,
// and random frames checked against a frame-level reference model.
module tb_uart_frame_parser;

    typedef logic [191:0] bvec_t;
    typedef logic [127:0] ovec_t;
    typedef struct {
        bvec_t      bytes;
        int         n;
        ovec_t      outs;
        int         n_out;
        logic [2:0] err;
        logic [7:0] cmd;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] frame_cmd;
    logic       frame_done;
    logic       frame_ok;
    logic [2:0] err_code;
    logic       busy;

    logic [8:0]  exp_q[$];
    logic [10:0] exp_st_q[$];
    int          n_checks;
    int          n_fail;
    int          done_cnt;
    int          exp_total;
    bit          rand_ready;
    vec_t        tbl[8];

    uart_frame_parser #(
        .FIFO_DEPTH(4),
        .MAX_LEN(16),
        .HEADER(8'hAA),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .frame_cmd(frame_cmd),
        .frame_done(frame_done),
        .frame_ok(frame_ok),
        .err_code(err_code),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endfunction

    function automatic vec_t mk(input bvec_t b, input int n, input ovec_t o, input int no,
                                input logic [2:0] err, input logic [7:0] cmd);
        vec_t v;
        v.bytes = b;
        v.n     = n;
        v.outs  = o;
        v.n_out = no;
        v.err   = err;
        v.cmd   = cmd;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_frames(input int target, input string name);
        int k = 0;
        while (done_cnt < target && k < 200) begin
            tick();
            k++;
        end
        check(name, 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            tick();
            k++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic expect_status(input logic [2:0] err, input logic [7:0] cmd);
        exp_st_q.push_back({err, cmd});
        exp_total++;
    endtask

    initial begin
        logic [10:0] st;
        logic [8:0]  e;
        rst        = 1'b1;
        rx_data    = 8'h00;
        rx_done    = 1'b0;
        out_ready  = 1'b0;
        rand_ready = 1'b0;
        n_checks   = 0;
        n_fail     = 0;
        done_cnt   = 0;
        exp_total  = 0;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_pop: got %0h required no byte", {out_last, out_data});
                        end else begin
                            e = exp_q.pop_front();
                            check("out_byte", 32'({out_last, out_data}), 32'(e));
                        end
                    end
                    if (frame_done) begin
                        done_cnt++;
                        if (exp_st_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_done: got err %0d required no frame_done", err_code);
                        end else begin
                            st = exp_st_q.pop_front();
                            check("frame_status", 32'({frame_ok, err_code, frame_cmd}),
                                  32'({(st[10:8] == 3'd0), st[10:8], st[7:0]}));
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({out_valid, out_last, out_data, frame_cmd, frame_done, frame_ok, err_code, busy}), 32'd0);
        rst = 1'b0;
        tick();

        // Directed frame table
        tbl[0] = mk(bvec_t'({8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33}), 6, ovec_t'({8'h10, 8'h20}), 2, 3'd0, 8'h01);
        tbl[1] = mk(bvec_t'({8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34}), 6, ovec_t'({8'h10, 8'h20}), 2, 3'd1, 8'h01);
        tbl[2] = mk(bvec_t'({8'h55, 8'hAA, 8'h05, 8'h00, 8'h05}), 5, ovec_t'(0), 0, 3'd0, 8'h05);
        tbl[3] = mk(bvec_t'({8'hAA, 8'h01, 8'h11}), 3, ovec_t'(0), 0, 3'd2, 8'h01);
        tbl[4] = mk(bvec_t'({8'hAA, 8'h02, 8'h01, 8'h7F, 8'h7C}), 5, ovec_t'({8'h7F}), 1, 3'd0, 8'h02);
        tbl[5] = mk(bvec_t'({8'hAA, 8'h07, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                             8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h17}), 20,
                    ovec_t'({8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                             8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F}), 16, 3'd0, 8'h07);
        tbl[6] = mk(bvec_t'({8'hAA, 8'hAA, 8'h01, 8'hAA, 8'h01}), 5, ovec_t'({8'hAA}), 1, 3'd0, 8'hAA);
        tbl[7] = mk(bvec_t'({8'hAA, 8'h09, 8'h00, 8'h08}), 4, ovec_t'(0), 0, 3'd1, 8'h09);

        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < tbl[r].n_out; i++) begin
                exp_q.push_back({(i == tbl[r].n_out - 1), tbl[r].outs[8*(tbl[r].n_out-1-i) +: 8]});
            end
            expect_status(tbl[r].err, tbl[r].cmd);
            for (int i = 0; i < tbl[r].n; i++) begin
                send_byte(tbl[r].bytes[8*(tbl[r].n-1-i) +: 8], r % 2);
            end
            wait_frames(exp_total, "table_done");
            wait_drain("table_drain");
        end

        // Length error pulses exactly one cycle after the len strobe
        expect_status(3'd2, 8'h21);
        send_byte(8'hAA, 1);
        send_byte(8'h21, 1);
        check("len_err_before", 32'(frame_done), 32'd0);
        send_byte(8'h11, 0);
        check("len_err_pulse", 32'({frame_done, busy}), 32'b10);
        tick();
        check("len_err_single", 32'(frame_done), 32'd0);
        wait_frames(exp_total, "len_err_done");

        // Overflow: FIFO depth 4, six payload bytes, consumer stalled
        out_ready = 1'b0;
        expect_status(3'd3, 8'h03);
        for (int i = 1; i <= 4; i++) exp_q.push_back({1'b0, 8'(i)});
        send_byte(8'hAA, 1);
        send_byte(8'h03, 1);
        send_byte(8'h06, 1);
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1);
        send_byte(8'h02, 1);
        wait_frames(exp_total, "ovf_done");
        tick();
        check("ovf_head", 32'({out_valid, out_last, out_data}), 32'({1'b1, 1'b0, 8'h01}));
        out_ready = 1'b1;
        wait_drain("ovf_drain");
        tick();
        check("ovf_empty", 32'(out_valid), 32'd0);

        // Push into a full FIFO in the same cycle as a pop is kept
        out_ready = 1'b0;
        expect_status(3'd0, 8'h04);
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b0, 8'h33});
        exp_q.push_back({1'b0, 8'h44});
        exp_q.push_back({1'b1, 8'h55});
        send_byte(8'hAA, 1);
        send_byte(8'h04, 1);
        send_byte(8'h05, 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        send_byte(8'h33, 1);
        send_byte(8'h44, 1);
        out_ready = 1'b1;
        send_byte(8'h55, 1);
        send_byte(8'h10, 1);
        wait_frames(exp_total, "fullpop_done");
        wait_drain("fullpop_drain");

        // Reset in the middle of a payload
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 8'h10});
        send_byte(8'hAA, 1);
        send_byte(8'h01, 1);
        send_byte(8'h04, 1);
        send_byte(8'h10, 1);
        check("pre_reset_busy", 32'({busy, out_valid}), 32'b11);
        rst = 1'b1;
        #1;
        check("mid_reset", 32'({busy, out_valid, out_last, out_data, frame_cmd}), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        expect_status(3'd0, 8'h02);
        exp_q.push_back({1'b1, 8'h7F});
        send_byte(8'hAA, 1);
        send_byte(8'h02, 1);
        send_byte(8'h01, 1);
        send_byte(8'h7F, 1);
        send_byte(8'h7C, 1);
        wait_frames(exp_total, "post_reset_done");
        wait_drain("post_reset_drain");

`ifdef UFP_TIMEOUT_EN
        begin
            int k;
            expect_status(3'd4, 8'h01);
            send_byte(8'hAA, 0);
            send_byte(8'h01, 0);
            k = 0;
            while (done_cnt < exp_total && k < 200) begin
                tick();
                k++;
            end
            check("timeout_latency", 32'((k >= 98) && (k <= 104)), 32'd1);
            check("timeout_idle", 32'(busy), 32'd0);
        end
`endif

        // Random frames against the frame-level model, consumer randomly stalling
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            logic [7:0] cmd;
            logic [7:0] len;
            logic [7:0] sum;
            logic [7:0] b;
            bit         bad;
            int         junk;
            junk = $urandom_range(0, 2);
            for (int j = 0; j < junk; j++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hAA) b = 8'h55;
                send_byte(b, $urandom_range(0, 3));
            end
            cmd = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) len = 8'($urandom_range(17, 255));
            else len = 8'($urandom_range(0, 4));
            send_byte(8'hAA, $urandom_range(0, 3));
            send_byte(cmd, $urandom_range(0, 3));
            if (len > 8'd16) begin
                expect_status(3'd2, cmd);
                send_byte(len, $urandom_range(0, 3));
            end else begin
                send_byte(len, $urandom_range(0, 3));
                sum = cmd ^ len;
                for (int i = 0; i < int'(len); i++) begin
                    b = 8'($urandom_range(0, 255));
                    sum = sum ^ b;
                    exp_q.push_back({(i == int'(len) - 1), b});
                    send_byte(b, $urandom_range(0, 3));
                end
                bad = ($urandom_range(0, 3) == 0);
                expect_status(bad ? 3'd1 : 3'd0, cmd);
                send_byte(bad ? (sum ^ 8'($urandom_range(1, 255))) : sum, $urandom_range(0, 3));
            end
            wait_frames(exp_total, "rand_done");
            wait_drain("rand_drain");
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("final_status_queue", 32'(exp_st_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
